// File: rtl/alu_issue_stage_if.sv
// +----------------------------------------------------------------------------+
// | Module : alu_issue_stage_if                                                |
// | Brief  : Fetch-side and execute-side handshake bundle of the ALU issue     |
// |          stage.                                                            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_alu_ctrl;
  logic            out_illegal;
  logic            out_is_branch;
  logic [2:0]      out_funct3;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_illegal,
           out_is_branch, out_funct3
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_illegal,
           out_is_branch, out_funct3
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// +----------------------------------------------------------------------------+
// | Module : alu_issue_stage                                                   |
// | Brief  : RV32I decode/issue stage with 2-entry skid buffer feeding the ALU.|
// |          Optional macro ALU_ISSUE_PERF_CNT_EN adds issue/illegal counters. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               flush,
  alu_issue_stage_if.slave  bus
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_illegal
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic            illegal;
    logic            is_branch;
    logic [2:0]      funct3;
  } pkt_t;

  pkt_t out_pkt_q, out_pkt_d, skid_pkt_q, skid_pkt_d, dec_pkt;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic accept;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  logic            unused_instr_bits;

  assign opcode = bus.in_instr[6:0];
  assign f3     = bus.in_instr[14:12];
  assign f7     = bus.in_instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
  assign imm_u  = {{(XLEN-32){bus.in_instr[31]}}, bus.in_instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
  assign unused_instr_bits = ^bus.in_instr[19:15];

  always_comb begin
    dec_pkt           = '0;
    dec_pkt.funct3    = f3;
    dec_pkt.ctrl      = ALU_ADD;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_pkt.a = bus.in_rs1;
        dec_pkt.b = (opcode == OPC_OP) ? bus.in_rs2 : imm_i;
        case (f3)
          3'b000: begin
            if (opcode == OPC_OP) begin
              dec_pkt.ctrl    = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
              dec_pkt.illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
            end
          end
          3'b001: dec_pkt.ctrl = ALU_SLL;
          3'b010: dec_pkt.ctrl = ALU_SLT;
          3'b011: dec_pkt.ctrl = ALU_SLTU;
          3'b100: dec_pkt.ctrl = ALU_XOR;
          3'b101: begin
            dec_pkt.ctrl    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_pkt.illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
          end
          3'b110: dec_pkt.ctrl = ALU_OR;
          default: dec_pkt.ctrl = ALU_AND;
        endcase
        // Register forms only allow funct7 variants on ADD/SUB and SRL/SRA;
        // immediate shifts carry the shift amount, not the raw I-immediate.
        if (opcode == OPC_OP && f3 != 3'b000 && f3 != 3'b101 && f7 != F7_ZERO)
          dec_pkt.illegal = 1'b1;
        if (opcode == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
          dec_pkt.b = shamt;
          if (f3 == 3'b001 && f7 != F7_ZERO)
            dec_pkt.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_pkt.a = bus.in_rs1;
        dec_pkt.b = imm_i;
      end
      OPC_STORE: begin
        dec_pkt.a = bus.in_rs1;
        dec_pkt.b = imm_s;
      end
      OPC_BRANCH: begin
        dec_pkt.a         = bus.in_rs1;
        dec_pkt.b         = bus.in_rs2;
        dec_pkt.is_branch = 1'b1;
        case (f3[2:1])
          2'b00:   dec_pkt.ctrl    = ALU_SUB;
          2'b10:   dec_pkt.ctrl    = ALU_SLT;
          2'b11:   dec_pkt.ctrl    = ALU_SLTU;
          default: dec_pkt.illegal = 1'b1;
        endcase
      end
      OPC_LUI: dec_pkt.b = imm_u;
      OPC_AUIPC: begin
        dec_pkt.a = bus.in_pc;
        dec_pkt.b = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec_pkt.a       = bus.in_pc;
        dec_pkt.b       = XLEN'(4);
        dec_pkt.illegal = (opcode == OPC_JALR) && (f3 != 3'b000);
      end
      default: dec_pkt.illegal = 1'b1;
    endcase
    if (dec_pkt.illegal) begin
      dec_pkt.a         = '0;
      dec_pkt.b         = '0;
      dec_pkt.ctrl      = ALU_ADD;
      dec_pkt.is_branch = 1'b0;
    end
  end

  // in_ready depends only on skid occupancy, so accept never collides with a full skid.
  assign accept = bus.in_valid && !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pkt_d    = out_pkt_q;
    skid_valid_d = skid_valid_q;
    skid_pkt_d   = skid_pkt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_pkt_d    = skid_pkt_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_pkt_d   = dec_pkt;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_pkt_d   = dec_pkt;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_pkt_q    <= '0;
      skid_pkt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_pkt_q    <= out_pkt_d;
      skid_pkt_q   <= skid_pkt_d;
    end
  end

  assign bus.in_ready      = !skid_valid_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_a         = out_pkt_q.a;
  assign bus.out_b         = out_pkt_q.b;
  assign bus.out_alu_ctrl  = out_pkt_q.ctrl;
  assign bus.out_illegal   = out_pkt_q.illegal;
  assign bus.out_is_branch = out_pkt_q.is_branch;
  assign bus.out_funct3    = out_pkt_q.funct3;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued_q  <= '0;
      perf_illegal_q <= '0;
    end else if (out_valid_q && bus.out_ready && !flush) begin
      perf_issued_q <= perf_issued_q + 32'd1;
      if (out_pkt_q.illegal)
        perf_illegal_q <= perf_illegal_q + 32'd1;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_illegal = perf_illegal_q;
`else
  // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// +----------------------------------------------------------------------------+
// | Module : tb_alu_issue_stage                                                |
// | Brief  : Directed self-checking bench for alu_issue_stage.                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_issued = 0;
  int   exp_illegal = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32)) bus ();

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued, perf_illegal;
  alu_issue_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .perf_issued  (perf_issued),
    .perf_illegal (perf_illegal)
  );
`else
  alu_issue_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    n_cmp++; if ({bus.out_a, bus.out_b, bus.out_alu_ctrl, bus.out_illegal, bus.out_is_branch, bus.out_funct3} !== 73'd0) begin
      n_err++; $display("FAIL reset_pkt got a=%h b=%h ctrl=%b want all zero", bus.out_a, bus.out_b, bus.out_alu_ctrl);
    end
`ifdef ALU_ISSUE_PERF_CNT_EN
    n_cmp++; if (perf_issued !== 32'd0 || perf_illegal !== 32'd0) begin
      n_err++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_issued, perf_illegal);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive(32'h00B50533, 32'h0, 32'd5, 32'd7);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_alu_ctrl !== 4'b0000 || bus.out_a !== 32'd5 || bus.out_b !== 32'd7 || bus.out_illegal !== 1'b0) begin
      n_err++; $display("FAIL add got v=%b ctrl=%b a=%h b=%h ill=%b want 1 0000 5 7 0", bus.out_valid, bus.out_alu_ctrl, bus.out_a, bus.out_b, bus.out_illegal);
    end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got valid %b want 0", bus.out_valid); end
    exp_issued += 1;
  endtask

  task automatic test_back_to_back();
    drive(32'h40B50533, 32'h0, 32'd10, 32'd3);
    tick();
    drive(32'h40335313, 32'h0, 32'h80000000, 32'd0);
    n_cmp++; if (bus.out_alu_ctrl !== 4'b0001 || bus.out_a !== 32'd10 || bus.out_b !== 32'd3) begin
      n_err++; $display("FAIL sub got ctrl=%b a=%h b=%h want 0001 a b=3", bus.out_alu_ctrl, bus.out_a, bus.out_b);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_alu_ctrl !== 4'b0111 || bus.out_a !== 32'h80000000 || bus.out_b !== 32'd3) begin
      n_err++; $display("FAIL srai got v=%b ctrl=%b a=%h b=%h want 1 0111 80000000 3", bus.out_valid, bus.out_alu_ctrl, bus.out_a, bus.out_b);
    end
    tick();
    exp_issued += 2;
  endtask

  task automatic test_imm();
    drive(32'hFFF00293, 32'h0, 32'd100, 32'd0);
    tick();
    drive(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF);
    n_cmp++; if (bus.out_alu_ctrl !== 4'b0000 || bus.out_a !== 32'd100 || bus.out_b !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL addi got ctrl=%b a=%h b=%h want 0000 64 ffffffff", bus.out_alu_ctrl, bus.out_a, bus.out_b);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_alu_ctrl !== 4'b0000 || bus.out_a !== 32'd0 || bus.out_b !== 32'h12345000) begin
      n_err++; $display("FAIL lui got ctrl=%b a=%h b=%h want 0000 0 12345000", bus.out_alu_ctrl, bus.out_a, bus.out_b);
    end
    tick();
    exp_issued += 2;
  endtask

  task automatic test_branch_illegal();
    drive(32'h00B50463, 32'h40, 32'd1, 32'd2);
    tick();
    drive(32'h00000000, 32'h44, 32'd9, 32'd9);
    n_cmp++; if (bus.out_alu_ctrl !== 4'b0001 || bus.out_is_branch !== 1'b1 || bus.out_funct3 !== 3'b000 || bus.out_a !== 32'd1 || bus.out_b !== 32'd2 || bus.out_illegal !== 1'b0) begin
      n_err++; $display("FAIL beq got ctrl=%b br=%b f3=%b a=%h b=%h ill=%b want 0001 1 000 1 2 0", bus.out_alu_ctrl, bus.out_is_branch, bus.out_funct3, bus.out_a, bus.out_b, bus.out_illegal);
    end
    tick();
    drive(32'h0000006F, 32'h100, 32'd9, 32'd9);
    n_cmp++; if (bus.out_illegal !== 1'b1 || bus.out_alu_ctrl !== 4'b0000 || bus.out_a !== 32'd0 || bus.out_b !== 32'd0 || bus.out_is_branch !== 1'b0) begin
      n_err++; $display("FAIL zero_instr got ill=%b ctrl=%b a=%h b=%h br=%b want 1 0000 0 0 0", bus.out_illegal, bus.out_alu_ctrl, bus.out_a, bus.out_b, bus.out_is_branch);
    end
    tick();
    drive(32'h02B50533, 32'h0, 32'd9, 32'd9);
    n_cmp++; if (bus.out_illegal !== 1'b0 || bus.out_a !== 32'h100 || bus.out_b !== 32'd4 || bus.out_alu_ctrl !== 4'b0000) begin
      n_err++; $display("FAIL jal got ill=%b a=%h b=%h ctrl=%b want 0 100 4 0000", bus.out_illegal, bus.out_a, bus.out_b, bus.out_alu_ctrl);
    end
    tick();
    drive(32'h00B52463, 32'h0, 32'd9, 32'd9);
    n_cmp++; if (bus.out_illegal !== 1'b1 || bus.out_a !== 32'd0) begin
      n_err++; $display("FAIL op_bad_f7 got ill=%b a=%h want 1 0", bus.out_illegal, bus.out_a);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_illegal !== 1'b1 || bus.out_is_branch !== 1'b0 || bus.out_funct3 !== 3'b010 || bus.out_b !== 32'd0) begin
      n_err++; $display("FAIL branch_f3_010 got ill=%b br=%b f3=%b b=%h want 1 0 010 0", bus.out_illegal, bus.out_is_branch, bus.out_funct3, bus.out_b);
    end
    tick();
    exp_issued  += 5;
    exp_illegal += 3;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(32'h00B50533, 32'h0, 32'h11, 32'h0);
    tick();
    drive(32'h00B50533, 32'h0, 32'h22, 32'h0);
    tick();
    drive(32'h00B50533, 32'h0, 32'h33, 32'h0);
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_a !== 32'h11) begin
      n_err++; $display("FAIL bp_full got rdy=%b v=%b a=%h want 0 1 11", bus.in_ready, bus.out_valid, bus.out_a);
    end
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_a !== 32'h11) begin
      n_err++; $display("FAIL bp_hold got rdy=%b a=%h want 0 11", bus.in_ready, bus.out_a);
    end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h22 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_second got v=%b a=%h rdy=%b want 1 22 1", bus.out_valid, bus.out_a, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h33) begin
      n_err++; $display("FAIL bp_third got v=%b a=%h want 1 33", bus.out_valid, bus.out_a);
    end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got v=%b want 0", bus.out_valid); end
    exp_issued += 3;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(32'h00B50533, 32'h0, 32'h44, 32'h0);
    tick();
    drive(32'h00B50533, 32'h0, 32'h55, 32'h0);
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_prefill got rdy=%b want 0", bus.in_ready); end
    drive(32'h00B50533, 32'h0, 32'h5A, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_full got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    drive(32'h00B50533, 32'h0, 32'h5B, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard got v=%b want 0", bus.out_valid); end
`ifdef ALU_ISSUE_PERF_CNT_EN
    n_cmp++; if (perf_issued !== 32'(exp_issued) || perf_illegal !== 32'(exp_illegal)) begin
      n_err++; $display("FAIL perf_after_flush got %0d/%0d want %0d/%0d", perf_issued, perf_illegal, exp_issued, exp_illegal);
    end
`endif
    bus.out_ready = 1'b1;
    drive(32'h00B50533, 32'h0, 32'h66, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h66 || bus.out_b !== 32'h1) begin
      n_err++; $display("FAIL post_flush got v=%b a=%h b=%h want 1 66 1", bus.out_valid, bus.out_a, bus.out_b);
    end
    tick();
    exp_issued += 1;
`ifdef ALU_ISSUE_PERF_CNT_EN
    n_cmp++; if (perf_issued !== 32'(exp_issued) || perf_illegal !== 32'(exp_illegal)) begin
      n_err++; $display("FAIL perf_final got %0d/%0d want %0d/%0d", perf_issued, perf_illegal, exp_issued, exp_illegal);
    end
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_imm();
    test_branch_illegal();
    test_backpressure();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
